// File: rtl/pwm_duty_decoder_pkg.sv
// rtl/pwm_duty_decoder_pkg.sv - shared types and constants for the PWM duty decoder
//
// Purpose: FSM state encoding and default geometry. The defaults match the
// breathing-LED generator's 6-bit counter, which has a 64-tick period.
// Ports: none (package).
package pwm_duty_decoder_pkg;

  localparam int unsigned DEF_WIDTH  = 6;
  localparam int unsigned DEF_PERIOD = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STUCK   = 2'd2
  } state_e;

  // A line with no rising edge for two nominal periods is declared stuck.
  function automatic int unsigned timeout_ticks(input int unsigned period);
    return 2 * period;
  endfunction

endpackage

// File: rtl/pwm_sample_tick.sv
// rtl/pwm_sample_tick.sv - input synchroniser, sample-tick divider and edge detector
//
// Purpose: brings the asynchronous PWM line into the clock domain and produces
// a one-cycle sample tick every PRESCALE cycles while enabled. It also reports
// the sampled level and a rising edge seen between consecutive ticks.
// Ports:
//   clk_i     system clock
//   reset_i   synchronous active-high reset
//   enable_i  1 = divider runs and ticks are produced
//   pulse_i   asynchronous PWM line
//   tick_o    one-cycle sample strobe
//   level_o   synchronised line level, meaningful when tick_o=1
//   rise_o    tick_o and level 1 while the previous tick sample was 0
module pwm_sample_tick #(
  parameter int unsigned PRESCALE = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic pulse_i,
  output logic tick_o,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;
  logic [DIV_W-1:0] div_q;

  assign tick_o  = enable_i && (div_q == DIV_LAST);
  assign level_o = sync2_q;
  assign rise_o  = tick_o && sync2_q && !prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      div_q   <= '0;
    end else begin
      sync1_q <= pulse_i;
      sync2_q <= sync1_q;
      // Divider restarts from zero whenever decoding is paused.
      if (!enable_i || tick_o) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + 1'b1;
      end
      // The previous sample only advances on ticks, so edges are tick-to-tick.
      if (tick_o) begin
        prev_q <= sync2_q;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - measures high time and period of an incoming PWM line
//
// Purpose: measures each PWM period from one rising edge to the next. It
// reports the saturated high time and the period length, and flags a line
// with no rising edge for TIMEOUT ticks as stuck.
// Ports:
//   sysclk      system clock
//   reset       synchronous active-high reset
//   Enable      1 = decode; 0 = hold in IDLE with outputs frozen
//   Pulse_In    asynchronous PWM input
//   Duty_Cycle  high ticks of last period, saturated to 2**WIDTH-1
//   Period      ticks in last period, 0 after a timeout
//   Valid       one-cycle strobe when the outputs above update
//   Stuck       last report was a timeout
module pwm_duty_decoder
  import pwm_duty_decoder_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned PERIOD   = DEF_PERIOD,
  parameter int unsigned PRESCALE = 2
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             Enable,
  input  logic             Pulse_In,
  output logic [WIDTH-1:0] Duty_Cycle,
  output logic [WIDTH+1:0] Period,
  output logic             Valid,
  output logic             Stuck
);

  localparam logic [WIDTH+1:0] TIMEOUT_CNT = (WIDTH + 2)'(timeout_ticks(PERIOD));
  localparam logic [WIDTH-1:0] DUTY_FULL   = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   HIGH_ONE    = (WIDTH + 1)'(1);
  localparam logic [WIDTH+1:0] PER_ONE     = (WIDTH + 2)'(1);

  logic tick;
  logic level;
  logic rise;

  pwm_sample_tick #(
    .PRESCALE (PRESCALE)
  ) u_sample (
    .clk_i    (sysclk),
    .reset_i  (reset),
    .enable_i (Enable),
    .pulse_i  (Pulse_In),
    .tick_o   (tick),
    .level_o  (level),
    .rise_o   (rise)
  );

  state_e           state_q,  state_d;
  logic [WIDTH:0]   high_q,   high_d;
  logic [WIDTH+1:0] per_q,    per_d;
  logic [WIDTH-1:0] duty_q,   duty_d;
  logic [WIDTH+1:0] period_q, period_d;
  logic             valid_q,  valid_d;
  logic             stuck_q,  stuck_d;

  always_comb begin
    state_d  = state_q;
    high_d   = high_q;
    per_d    = per_q;
    duty_d   = duty_q;
    period_d = period_q;
    stuck_d  = stuck_q;
    valid_d  = 1'b0;
    if (!Enable) begin
      state_d = ST_IDLE;
      high_d  = '0;
      per_d   = '0;
    end else if (tick) begin
      case (state_q)
        ST_IDLE, ST_STUCK: begin
          // The first period after IDLE or STUCK is partial and is never reported.
          if (rise) begin
            state_d = ST_MEASURE;
            high_d  = HIGH_ONE;
            per_d   = PER_ONE;
          end
        end
        ST_MEASURE: begin
          // Checking the edge before the timeout lets an edge on the timeout tick win.
          if (rise) begin
            duty_d   = (high_q > {1'b0, DUTY_FULL}) ? DUTY_FULL : high_q[WIDTH-1:0];
            period_d = per_q;
            stuck_d  = 1'b0;
            valid_d  = 1'b1;
            high_d   = HIGH_ONE;
            per_d    = PER_ONE;
          end else if (per_q == TIMEOUT_CNT) begin
            state_d  = ST_STUCK;
            duty_d   = level ? DUTY_FULL : '0;
            period_d = '0;
            stuck_d  = 1'b1;
            valid_d  = 1'b1;
            high_d   = '0;
            per_d    = '0;
          end else begin
            per_d = per_q + 1'b1;
            if (level) begin
              high_d = high_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      high_q   <= '0;
      per_q    <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      high_q   <= high_d;
      per_q    <= per_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  assign Duty_Cycle = duty_q;
  assign Period     = period_q;
  assign Valid      = valid_q;
  assign Stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb/tb_pwm_duty_decoder.sv - scoreboard bench for pwm_duty_decoder
module tb_pwm_duty_decoder;

  localparam int W  = 6;
  localparam int PS = 3;

  logic          sysclk = 1'b0;
  logic          reset;
  logic          Enable;
  logic          Pulse_In;
  logic [W-1:0]  Duty_Cycle;
  logic [W+1:0]  Period;
  logic          Valid;
  logic          Stuck;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    int duty;
    int per;
    int stk;
  } rep_t;

  rep_t sb[$];
  logic prev_valid = 1'b0;

  always #5 sysclk = ~sysclk;

  pwm_duty_decoder #(
    .WIDTH    (W),
    .PERIOD   (64),
    .PRESCALE (PS)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .Enable     (Enable),
    .Pulse_In   (Pulse_In),
    .Duty_Cycle (Duty_Cycle),
    .Period     (Period),
    .Valid      (Valid),
    .Stuck      (Stuck)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input int duty, input int per, input int stk);
    rep_t r;
    r.duty = duty;
    r.per  = per;
    r.stk  = stk;
    sb.push_back(r);
  endtask

  // Hold the line at lvl for n sample ticks (n*PS clocks).
  task automatic seg(input logic lvl, input int n);
    Pulse_In = lvl;
    repeat (n * PS) @(posedge sysclk);
    #1;
  endtask

  always @(negedge sysclk) begin
    if (Valid) begin
      chk("valid_gap", int'(prev_valid), 0);
      if (sb.size() == 0) begin
        chk("spurious_valid", sb.size(), 1);
      end else begin
        rep_t r;
        r = sb.pop_front();
        chk("duty", int'(Duty_Cycle), r.duty);
        chk("period", int'(Period), r.per);
        chk("stuck", int'(Stuck), r.stk);
      end
    end
    prev_valid = Valid;
  end

  initial begin
    reset    = 1'b1;
    Enable   = 1'b1;
    Pulse_In = 1'b0;
    repeat (4) @(posedge sysclk);
    #1;
    chk("rst_duty", int'(Duty_Cycle), 0);
    chk("rst_period", int'(Period), 0);
    chk("rst_valid", int'(Valid), 0);
    chk("rst_stuck", int'(Stuck), 0);
    reset = 1'b0;

    // Ideal PWM 21/64: first edge silent, then one report per closing edge.
    seg(1'b0, 5);
    repeat (3) push(21, 64, 0);
    repeat (3) begin
      seg(1'b1, 21);
      seg(1'b0, 43);
    end
    // Period 100, high 90: duty saturates.
    push(63, 100, 0);
    seg(1'b1, 90);
    seg(1'b0, 10);
    // Next edge lands exactly on the timeout tick: normal report.
    push(5, 128, 0);
    seg(1'b1, 5);
    seg(1'b0, 123);
    // Line held high: one stuck report, then silence.
    push(63, 0, 1);
    seg(1'b1, 200);
    seg(1'b0, 54);
    // Recovery: first period partial, then 10/64.
    push(10, 64, 0);
    seg(1'b1, 10);
    seg(1'b0, 54);
    seg(1'b1, 10);
    // Line held low: stuck report with duty 0.
    push(0, 0, 1);
    seg(1'b0, 200);

    // Enable dropped mid-period: outputs hold, counters discarded.
    seg(1'b1, 7);
    seg(1'b0, 20);
    Enable = 1'b0;
    repeat (30) @(posedge sysclk);
    #1;
    chk("hold_duty", int'(Duty_Cycle), 0);
    chk("hold_period", int'(Period), 0);
    chk("hold_stuck", int'(Stuck), 1);
    Enable = 1'b1;
    push(12, 64, 0);
    push(12, 42, 0);
    seg(1'b0, 10);
    seg(1'b1, 12);
    seg(1'b0, 52);
    seg(1'b1, 12);
    seg(1'b0, 30);
    seg(1'b1, 3);
    seg(1'b0, 10);

    // Reset mid-operation clears outputs and returns to IDLE.
    reset = 1'b1;
    @(posedge sysclk);
    #1;
    chk("mid_rst_duty", int'(Duty_Cycle), 0);
    chk("mid_rst_period", int'(Period), 0);
    chk("mid_rst_valid", int'(Valid), 0);
    chk("mid_rst_stuck", int'(Stuck), 0);
    reset = 1'b0;
    push(5, 10, 0);
    seg(1'b0, 3);
    seg(1'b1, 5);
    seg(1'b0, 5);
    seg(1'b1, 5);
    seg(1'b0, 5);
    repeat (10) @(posedge sysclk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
